// File: rtl/bw_io_sstl_dq_lane_bscan.sv
// Byte-lane boundary-scan / parallel-scan controller for SSTL DQ pads.
// One WIDTH-bit BSR lane with shared OE and ODT cells, pscan register and bypass path.
module bw_io_sstl_dq_lane_bscan #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          BYPASS_REG = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clock_dr,
  input  logic             shift_dr,
  input  logic             update_dr,
  input  logic             mode_ctrl,
  input  logic             hiz_l,
  input  logic             bsi,
  output logic             bso,
  input  logic             ps_select,
  input  logic             se,
  input  logic             test_mode,
  input  logic             serial_in,
  output logic             serial_out,
  input  logic             bypass_enable,
  input  logic [WIDTH-1:0] bypass_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  input  logic             drv_oe,
  input  logic             odt_enable_mask,
  output logic             oe,
  output logic             odt_enable,
  input  logic [WIDTH-1:0] rcv_in,
  output logic [WIDTH-1:0] to_core,
  output logic             bscan_aligned
);

  localparam int unsigned BSR_LEN = 2 * WIDTH + 2;
  localparam int unsigned ODT_IDX = 2 * WIDTH;
  localparam int unsigned OE_IDX  = 2 * WIDTH + 1;
  localparam int unsigned CNT_W   = $clog2(BSR_LEN + 2);
  localparam int unsigned CNT_MAX = BSR_LEN + 1;

  logic [BSR_LEN-1:0] bsr_q, bsr_d;
  logic [BSR_LEN-1:0] upd_q, upd_d;
  logic [WIDTH-1:0]   ps_q, ps_d;
  logic [CNT_W-1:0]   shift_cnt_q, shift_cnt_d;
  logic [WIDTH-1:0]   byp;
  logic               odt_in;
  logic               kill;

  always_comb begin
    odt_in = ~(drv_oe | odt_enable_mask);
    kill   = ps_select ? se : test_mode;
  end

  // BSR shift/capture and alignment counter; cell in[i] at 2i, out[i] at 2i+1
  always_comb begin
    bsr_d       = bsr_q;
    shift_cnt_d = shift_cnt_q;
    if (clock_dr) begin
      if (shift_dr) begin
        bsr_d = {bsr_q[BSR_LEN-2:0], bsi};
        if (shift_cnt_q != CNT_W'(CNT_MAX)) begin
          shift_cnt_d = shift_cnt_q + CNT_W'(1);
        end
      end else begin
        for (int i = 0; i < int'(WIDTH); i++) begin
          bsr_d[2*i]   = rcv_in[i];
          bsr_d[2*i+1] = data_in[i];
        end
        bsr_d[ODT_IDX] = odt_in;
        bsr_d[OE_IDX]  = drv_oe;
        shift_cnt_d    = '0;
      end
    end
  end

  // Update register samples the pre-edge chain, independent of same-cycle shifting
  always_comb begin
    upd_d = upd_q;
    if (update_dr) begin
      upd_d = bsr_q;
    end
  end

  generate
    if (WIDTH > 1) begin : g_ps_wide
      always_comb begin
        ps_d = ps_q;
        if (se) begin
          ps_d = {ps_q[WIDTH-2:0], serial_in};
        end else if (ps_select) begin
          ps_d = rcv_in;
        end
      end
    end else begin : g_ps_single
      always_comb begin
        ps_d = ps_q;
        if (se) begin
          ps_d = serial_in;
        end else if (ps_select) begin
          ps_d = rcv_in;
        end
      end
    end
  endgenerate

  generate
    if (BYPASS_REG) begin : g_byp_reg
      logic [WIDTH-1:0] byp_q;
      logic [WIDTH-1:0] byp_d;

      always_comb begin
        byp_d = bypass_in;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          byp_q <= '0;
        end else begin
          byp_q <= byp_d;
        end
      end

      always_comb begin
        byp = byp_q;
      end
    end else begin : g_byp_comb
      always_comb begin
        byp = bypass_in;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bsr_q       <= '0;
      upd_q       <= '0;
      ps_q        <= '0;
      shift_cnt_q <= '0;
    end else begin
      bsr_q       <= bsr_d;
      upd_q       <= upd_d;
      ps_q        <= ps_d;
      shift_cnt_q <= shift_cnt_d;
    end
  end

  // Pad-side muxing: EXTEST from update register, otherwise functional path
  always_comb begin
    data_out   = '0;
    to_core    = '0;
    oe         = 1'b0;
    odt_enable = 1'b0;
    if (mode_ctrl) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        data_out[i] = upd_q[2*i+1];
        to_core[i]  = upd_q[2*i];
      end
      oe         = upd_q[OE_IDX] & hiz_l;
      odt_enable = upd_q[ODT_IDX] & hiz_l;
    end else begin
      data_out   = bypass_enable ? byp : data_in;
      to_core    = rcv_in;
      oe         = drv_oe & ~kill;
      odt_enable = odt_in & ~kill;
    end
  end

  always_comb begin
    bso           = bsr_q[BSR_LEN-1];
    serial_out    = ps_q[WIDTH-1];
    bscan_aligned = (shift_cnt_q == CNT_W'(BSR_LEN));
  end

endmodule

// File: tb/tb_bw_io_sstl_dq_lane_bscan.sv
// Randomized and directed bench for bw_io_sstl_dq_lane_bscan against a queue-based lane model.
module tb_bw_io_sstl_dq_lane_bscan;

  localparam int W   = 8;
  localparam int LEN = 2 * W + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         clock_dr, shift_dr, update_dr, mode_ctrl, hiz_l, bsi;
  logic         ps_select, se, test_mode, serial_in, bypass_enable;
  logic [W-1:0] bypass_in, data_in, rcv_in;
  logic         drv_oe, odt_enable_mask;

  logic         bso0, serial_out0, oe0, odt0, aligned0;
  logic [W-1:0] data_out0, to_core0;
  logic         bso1, serial_out1, oe1, odt1, aligned1;
  logic [W-1:0] data_out1, to_core1;

  int total = 0;
  int bad   = 0;

  // Model: chain queue front is the bso end (oe, odt, out[W-1], in[W-1], ..., out[0], in[0])
  bit           m_bsr[$];
  bit           m_upd[$];
  bit           m_ps[$];
  int           m_cnt;
  logic [W-1:0] m_byp;

  always #5 clk = ~clk;

  bw_io_sstl_dq_lane_bscan #(.WIDTH(W), .BYPASS_REG(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .clock_dr(clock_dr), .shift_dr(shift_dr), .update_dr(update_dr),
    .mode_ctrl(mode_ctrl), .hiz_l(hiz_l), .bsi(bsi), .bso(bso0), .ps_select(ps_select), .se(se),
    .test_mode(test_mode), .serial_in(serial_in), .serial_out(serial_out0),
    .bypass_enable(bypass_enable), .bypass_in(bypass_in), .data_in(data_in), .data_out(data_out0),
    .drv_oe(drv_oe), .odt_enable_mask(odt_enable_mask), .oe(oe0), .odt_enable(odt0),
    .rcv_in(rcv_in), .to_core(to_core0), .bscan_aligned(aligned0)
  );

  bw_io_sstl_dq_lane_bscan #(.WIDTH(W), .BYPASS_REG(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .clock_dr(clock_dr), .shift_dr(shift_dr), .update_dr(update_dr),
    .mode_ctrl(mode_ctrl), .hiz_l(hiz_l), .bsi(bsi), .bso(bso1), .ps_select(ps_select), .se(se),
    .test_mode(test_mode), .serial_in(serial_in), .serial_out(serial_out1),
    .bypass_enable(bypass_enable), .bypass_in(bypass_in), .data_in(data_in), .data_out(data_out1),
    .drv_oe(drv_oe), .odt_enable_mask(odt_enable_mask), .oe(oe1), .odt_enable(odt1),
    .rcv_in(rcv_in), .to_core(to_core1), .bscan_aligned(aligned1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_bsr = {};
    m_upd = {};
    m_ps  = {};
    for (int i = 0; i < LEN; i++) begin
      m_bsr.push_back(1'b0);
      m_upd.push_back(1'b0);
    end
    for (int i = 0; i < W; i++) m_ps.push_back(1'b0);
    m_cnt = 0;
    m_byp = '0;
  endtask

  task automatic m_edge();
    bit nb[$];
    nb = m_bsr;
    if (update_dr) m_upd = m_bsr;
    if (clock_dr && shift_dr) begin
      void'(nb.pop_front());
      nb.push_back(bsi);
      if (m_cnt < LEN + 1) m_cnt++;
    end else if (clock_dr) begin
      nb = {};
      nb.push_back(drv_oe);
      nb.push_back(~(drv_oe | odt_enable_mask));
      for (int i = W - 1; i >= 0; i--) begin
        nb.push_back(data_in[i]);
        nb.push_back(rcv_in[i]);
      end
      m_cnt = 0;
    end
    m_bsr = nb;
    if (se) begin
      void'(m_ps.pop_front());
      m_ps.push_back(serial_in);
    end else if (ps_select) begin
      m_ps = {};
      for (int i = W - 1; i >= 0; i--) m_ps.push_back(rcv_in[i]);
    end
    m_byp = bypass_in;
  endtask

  task automatic check_outputs();
    logic [W-1:0] e_do0, e_do1, e_tc;
    logic         e_oe, e_odt, kill;
    kill = ps_select ? se : test_mode;
    if (mode_ctrl) begin
      for (int i = 0; i < W; i++) begin
        e_do0[i] = m_upd[2 + 2 * (W - 1 - i)];
        e_tc[i]  = m_upd[3 + 2 * (W - 1 - i)];
      end
      e_do1 = e_do0;
      e_oe  = m_upd[0] & hiz_l;
      e_odt = m_upd[1] & hiz_l;
    end else begin
      e_do0 = bypass_enable ? bypass_in : data_in;
      e_do1 = bypass_enable ? m_byp : data_in;
      e_tc  = rcv_in;
      e_oe  = drv_oe & ~kill;
      e_odt = ~(drv_oe | odt_enable_mask) & ~kill;
    end
    chk("data_out", 32'(data_out0), 32'(e_do0));
    chk("data_out_reg", 32'(data_out1), 32'(e_do1));
    chk("to_core", 32'(to_core0), 32'(e_tc));
    chk("oe", 32'(oe0), 32'(e_oe));
    chk("odt_enable", 32'(odt0), 32'(e_odt));
    chk("bso", 32'(bso0), 32'(m_bsr[0]));
    chk("serial_out", 32'(serial_out0), 32'(m_ps[0]));
    chk("bscan_aligned", 32'(aligned0), 32'(m_cnt == LEN));
  endtask

  // Inputs are set before calling; checks at negedge, model advances on posedge
  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic set_idle();
    clock_dr = 0; shift_dr = 0; update_dr = 0; mode_ctrl = 0; hiz_l = 1; bsi = 0;
    ps_select = 0; se = 0; test_mode = 0; serial_in = 0; bypass_enable = 0;
    bypass_in = '0; data_in = '0; rcv_in = '0; drv_oe = 0; odt_enable_mask = 0;
  endtask

  initial begin
    bit           stream[LEN];
    bit           pat[LEN];
    logic [W-1:0] cap_rcv, cap_din;

    set_idle();
    mode_ctrl = 1;
    rst = 1;
    m_reset();
    #12;
    chk("rst_oe", 32'(oe0), 32'd0);
    chk("rst_odt", 32'(odt0), 32'd0);
    chk("rst_data_out", 32'(data_out0), 32'd0);
    chk("rst_bso", 32'(bso0), 32'd0);
    chk("rst_aligned", 32'(aligned0), 32'd0);
    chk("rst_serial_out", 32'(serial_out0), 32'd0);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;

    // Capture then shift the whole chain out
    set_idle();
    cap_rcv = 8'hA5;
    cap_din = 8'h3C;
    clock_dr = 1; rcv_in = cap_rcv; data_in = cap_din; drv_oe = 1;
    step();
    stream[0] = 1'b1;
    stream[1] = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      stream[2 + 2 * (W - 1 - i)] = cap_din[i];
      stream[3 + 2 * (W - 1 - i)] = cap_rcv[i];
    end
    shift_dr = 1;
    for (int k = 0; k < LEN; k++) begin
      chk("bso_stream", 32'(bso0), 32'(stream[k]));
      step();
    end
    chk("aligned_at_len", 32'(aligned0), 32'd1);
    step();
    chk("aligned_past_len", 32'(aligned0), 32'd0);

    // Shift in an EXTEST pattern and apply it
    for (int i = W - 1; i >= 0; i--) begin
      pat[2 + 2 * (W - 1 - i)] = ~i[0];
      pat[3 + 2 * (W - 1 - i)] = i[0];
    end
    pat[0] = 1'b1;
    pat[1] = 1'b1;
    for (int k = 0; k < LEN; k++) begin
      bsi = pat[k];
      step();
    end
    clock_dr = 0; shift_dr = 0; update_dr = 1;
    step();
    update_dr = 0; mode_ctrl = 1; hiz_l = 1;
    #1;
    chk("extest_data_out", 32'(data_out0), 32'h55);
    chk("extest_to_core", 32'(to_core0), 32'hAA);
    chk("extest_oe", 32'(oe0), 32'd1);
    chk("extest_odt", 32'(odt0), 32'd1);
    hiz_l = 0;
    #1;
    chk("hiz_oe", 32'(oe0), 32'd0);
    chk("hiz_odt", 32'(odt0), 32'd0);
    step();

    // Update in the same cycle as a shift takes the pre-shift chain
    hiz_l = 1; clock_dr = 1; shift_dr = 0; data_in = 8'h0F; rcv_in = 8'h00; drv_oe = 0;
    step();
    shift_dr = 1; update_dr = 1; bsi = 1;
    step();
    clock_dr = 0; shift_dr = 0; update_dr = 0;
    #1;
    chk("upd_preshift", 32'(data_out0), 32'h0F);
    step();

    // Functional OE kill
    set_idle();
    drv_oe = 1; ps_select = 1; se = 1;
    #1 chk("kill_pscan", 32'(oe0), 32'd0);
    step();
    ps_select = 0; se = 0; test_mode = 1;
    #1 chk("kill_test_mode", 32'(oe0), 32'd0);
    step();
    test_mode = 0;
    #1 chk("no_kill", 32'(oe0), 32'd1);
    step();

    // Parallel scan capture and shift
    set_idle();
    ps_select = 1; rcv_in = 8'h81;
    step();
    se = 1; serial_in = 0;
    for (int k = 0; k < W; k++) begin
      chk("pscan_stream", 32'(serial_out0), 32'((k == 0) || (k == W - 1)));
      step();
    end

    // Registered bypass is exactly one clock late
    set_idle();
    bypass_enable = 1; bypass_in = 8'hFF;
    step();
    bypass_in = 8'h00;
    #1;
    chk("byp_reg_late", 32'(data_out1), 32'hFF);
    chk("byp_comb_now", 32'(data_out0), 32'h00);
    step();
    chk("byp_reg_next", 32'(data_out1), 32'h00);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      clock_dr        = ($urandom_range(0, 3) != 0);
      shift_dr        = ($urandom_range(0, 15) != 0);
      update_dr       = ($urandom_range(0, 7) == 0);
      mode_ctrl       = $urandom_range(0, 1);
      hiz_l           = ($urandom_range(0, 3) != 0);
      bsi             = $urandom_range(0, 1);
      ps_select       = $urandom_range(0, 1);
      se              = $urandom_range(0, 1);
      test_mode       = $urandom_range(0, 1);
      serial_in       = $urandom_range(0, 1);
      bypass_enable   = $urandom_range(0, 1);
      bypass_in       = W'($urandom);
      data_in         = W'($urandom);
      rcv_in          = W'($urandom);
      drv_oe          = $urandom_range(0, 1);
      odt_enable_mask = $urandom_range(0, 1);
      step();
    end

    // Asynchronous reset in the middle of a shift
    set_idle();
    clock_dr = 1; shift_dr = 1; bsi = 1; ps_select = 1; rcv_in = 8'hFF;
    for (int k = 0; k < 5; k++) step();
    #2 rst = 1;
    m_reset();
    #1;
    chk("midrst_bso", 32'(bso0), 32'd0);
    chk("midrst_serial_out", 32'(serial_out0), 32'd0);
    chk("midrst_aligned", 32'(aligned0), 32'd0);
    @(negedge clk);
    rst = 0;
    set_idle();
    mode_ctrl = 1;
    @(posedge clk);
    m_edge();
    #1;
    for (int k = 0; k < 4; k++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
